sl_rx_scheduler: RTL and testbench
==================================

// Module: sl_rx_scheduler
// PURPOSE
//  Shares one host read/config port among N_CH SL receiver channels. Snapshots completed-word and error
//  events from each receiver into a per-channel slot and round-robins pending slots onto a valid/ready
//  output. Sequences config writes into a chosen receiver and verifies them by read-back, retrying while
//  the receiver is mid-word. Sits between the SL receiver array and the host bus/IRQ logic.
// PARAMETERS
//  N_CH          4    number of SL receiver channels (2..8)
//  STATUS_WIDTH  16   receiver status word width
//  CONFIG_WIDTH  16   receiver config word width
//  CFG_RETRY     255  max config write attempts before cfg_err (8-bit counter)
// PORTS
//  clk           in   1                   clock, 16 MHz
//  rst_n         in   1                   asynchronous reset, active low
//  ch_status     in   N_CH*STATUS_WIDTH   channel i status at [i*STATUS_WIDTH +: STATUS_WIDTH]
//  ch_data       in   N_CH*32             channel i buffered word at [i*32 +: 32]
//  ch_changed    in   N_CH                per-channel data_status_changed pulse
//  ch_cfg_rd     in   N_CH*CONFIG_WIDTH   per-channel config read-back
//  ch_cfg_wr     out  CONFIG_WIDTH        config word broadcast to all channels
//  ch_wr_en      out  N_CH                one-hot config write strobe
//  out_valid     out  1                   event word available
//  out_ready     in   1                   host accepts event word
//  out_ch        out  3                   channel number of the presented event
//  out_status    out  STATUS_WIDTH        status snapshot of the presented event
//  out_data      out  32                  data snapshot of the presented event
//  overrun       out  N_CH                sticky flag: pending slot overwritten
//  overrun_clr   in   N_CH                one-cycle clear of the overrun bits
//  cfg_req       in   1                   config request; held high until cfg_ack
//  cfg_ch        in   3                   target channel (stable while cfg_req)
//  cfg_data      in   CONFIG_WIDTH        config value (stable while cfg_req)
//  cfg_ack       out  1                   one-cycle pulse: request finished
//  cfg_err       out  1                   valid with cfg_ack: read-back never matched
//  irq           out  1                   equals out_valid
// BEHAVIOUR
//  Reset: all outputs 0; slots, pending, overrun, rr pointer (0) and retry counter (0) cleared; state IDLE.
//  Event qualify: ch_changed[i] & (status[3] WRF | status[5] LEF). Changed pulses without either bit
//   (word start) are ignored.
//  Capture: qualified event at edge t -> slot i <= {status,data}, pending[i] <= 1 at t+1. If pending[i]
//   is already 1 and the slot is not being granted that same cycle -> overwrite, overrun[i] <= 1.
//   If the slot is granted and captured in the same cycle: the grant takes the old contents, the new
//   event refills the slot, pending stays 1, and no overrun is raised. overrun_clr[i] and a new overrun
//   in the same cycle -> overrun stays 1.
//  FSM IDLE: cfg_req=1 -> CFG_WR (cfg_req has priority over events); else any pending -> GRANT.
//  GRANT (1 cycle): pick first pending channel searching from rr+1 modulo N_CH. Copy its slot into the
//   output registers, clear pending, rr <= channel, out_valid <= 1 -> PRESENT. Earliest out_valid is
//   t+3 after the event edge.
//  PRESENT: outputs held stable while out_valid & !out_ready. On the out_valid&out_ready edge ->
//   out_valid <= 0 -> IDLE. No back-to-back transfer; one idle cycle between words.
//  CFG_WR: ch_cfg_wr <= cfg_data, ch_wr_en[cfg_ch] <= 1 for exactly one cycle, attempt count += 1
//   -> CFG_WAIT.
//  CFG_WAIT: wait 3 cycles (receiver latches on an idle cycle), then compare
//   ch_cfg_rd[cfg_ch] == cfg_data. Equal -> cfg_ack=1, cfg_err=0 -> IDLE. Unequal and
//   count < CFG_RETRY -> CFG_WR. Unequal and count == CFG_RETRY -> cfg_ack=1, cfg_err=1 -> IDLE.
//   Count clears on ack. The receiver rejects odd or <8 bit-quantity words, so these end in cfg_err.
//  cfg_ch >= N_CH: immediate cfg_ack with cfg_err=1, no strobe.
//  Event capture continues in every state; only granting is blocked during config sequences.
//  cfg_req dropped before ack: undefined; not required to be handled.
//  Async reset mid-sequence: strobe drops immediately, slots are lost, no ack.
// TESTING
//  ch1 WRF event, data 32'hDEADBEEF, out_ready=1 -> out_valid at t+3, out_ch=1, out_data=DEADBEEF, 1 beat.
//  Events on ch0, ch2, ch3 in the same cycle, rr=0 -> grant order 2, 3, 0.
//  Two ch2 events while out_ready=0 and ch2 already pending -> overrun[2]=1; second word delivered;
//   overrun_clr[2] -> 0.
//  cfg_req ch0 = 16'h0010 with matching read-back on attempt 1 -> exactly 1 strobe, cfg_ack, cfg_err=0.
//  cfg_req cfg_data=16'h000E (BQ=7) with read-back never changing -> 255 strobes, then cfg_ack with
//   cfg_err=1.
//  Changed pulse with status WRP only -> no pending, out_valid stays 0; rst_n low mid-PRESENT
//   -> out_valid=0 immediately.

Source files
------------

// File: rtl/sl_rx_scheduler.sv
// sl_rx_scheduler: shares one host event/config port among N_CH SL receivers.
// Per-channel event slots are drained round-robin; config writes are verified by read-back with retry.
module sl_rx_scheduler #(
    parameter int N_CH         = 4,
    parameter int STATUS_WIDTH = 16,
    parameter int CONFIG_WIDTH = 16,
    parameter int CFG_RETRY    = 255
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [N_CH*STATUS_WIDTH-1:0]   ch_status,
    input  logic [N_CH*32-1:0]             ch_data,
    input  logic [N_CH-1:0]                ch_changed,
    input  logic [N_CH*CONFIG_WIDTH-1:0]   ch_cfg_rd,
    output logic [CONFIG_WIDTH-1:0]        ch_cfg_wr,
    output logic [N_CH-1:0]                ch_wr_en,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [2:0]                     out_ch,
    output logic [STATUS_WIDTH-1:0]        out_status,
    output logic [31:0]                    out_data,
    output logic [N_CH-1:0]                overrun,
    input  logic [N_CH-1:0]                overrun_clr,
    input  logic                           cfg_req,
    input  logic [2:0]                     cfg_ch,
    input  logic [CONFIG_WIDTH-1:0]        cfg_data,
    output logic                           cfg_ack,
    output logic                           cfg_err,
    output logic                           irq
);

    typedef enum logic [2:0] {IDLE, GRANT, PRESENT, CFG_WR, CFG_WAIT} state_t;

    state_t                  state, state_nxt;
    logic [STATUS_WIDTH-1:0] slot_status [N_CH];
    logic [31:0]             slot_data   [N_CH];
    logic [N_CH-1:0]         pending, pending_nxt, overrun_nxt;
    logic [N_CH-1:0]         capture, granted, cfg_onehot;
    logic [2:0]              rr, grant_ch;
    logic                    grant_found;
    logic [STATUS_WIDTH-1:0] grant_status;
    logic [31:0]             grant_data;
    logic [CONFIG_WIDTH-1:0] cfg_rd_sel;
    logic                    cfg_ch_bad;
    logic [7:0]              attempt;
    logic [1:0]              wait_cnt;
    logic                    grant_fire, accept, cfg_fire, ack_fire, err_val;

    // NOTE: combinational blocks use blocking '=' and assign every output a default first, so no latch is inferred.
    always_comb begin
        capture = '0;
        for (int i = 0; i < N_CH; i++) begin
            logic [STATUS_WIDTH-1:0] st;
            st         = ch_status[i*STATUS_WIDTH +: STATUS_WIDTH];
            // Only word-complete (WRF) or error (LEF) changes are events; word starts are not.
            capture[i] = ch_changed[i] & (st[3] | st[5]);
        end
    end

    always_comb begin
        grant_found = 1'b0;
        grant_ch    = '0;
        for (int k = 1; k <= N_CH; k++) begin
            for (int c = 0; c < N_CH; c++) begin
                if (!grant_found && pending[c] && (c == (int'(rr) + k) % N_CH)) begin
                    grant_found = 1'b1;
                    grant_ch    = 3'(c);
                end
            end
        end
    end

    always_comb begin
        grant_status = '0;
        grant_data   = '0;
        granted      = '0;
        cfg_ch_bad   = 1'b1;
        cfg_rd_sel   = '0;
        cfg_onehot   = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (grant_ch == 3'(c)) begin
                grant_status = slot_status[c];
                grant_data   = slot_data[c];
            end
            granted[c] = grant_fire && (grant_ch == 3'(c));
            if (cfg_ch == 3'(c)) begin
                cfg_ch_bad    = 1'b0;
                cfg_rd_sel    = ch_cfg_rd[c*CONFIG_WIDTH +: CONFIG_WIDTH];
                cfg_onehot[c] = 1'b1;
            end
        end
    end

    // A slot granted and refilled on the same edge hands its old word out and stays pending without overrun.
    always_comb begin
        pending_nxt = (pending & ~granted) | capture;
        overrun_nxt = (overrun & ~overrun_clr) | (capture & pending & ~granted);
    end

    // NOTE: slot storage is reset too, so a grant after reset can never present stale words.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
            overrun <= '0;
            for (int i = 0; i < N_CH; i++) begin
                slot_status[i] <= '0;
                slot_data[i]   <= '0;
            end
        end else begin
            // NOTE: sequential state uses non-blocking '<=' so every register samples pre-edge values.
            pending <= pending_nxt;
            overrun <= overrun_nxt;
            for (int i = 0; i < N_CH; i++) begin
                if (capture[i]) begin
                    slot_status[i] <= ch_status[i*STATUS_WIDTH +: STATUS_WIDTH];
                    slot_data[i]   <= ch_data[i*32 +: 32];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        grant_fire = 1'b0;
        accept     = 1'b0;
        cfg_fire   = 1'b0;
        ack_fire   = 1'b0;
        err_val    = 1'b0;
        case (state)
            IDLE: begin
                // cfg_ack high means the host has not yet dropped the request just finished.
                if (cfg_req && !cfg_ack) begin
                    if (cfg_ch_bad) begin
                        ack_fire = 1'b1;
                        err_val  = 1'b1;
                    end else begin
                        state_nxt = CFG_WR;
                    end
                end else if (|pending) begin
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                grant_fire = grant_found;
                state_nxt  = PRESENT;
            end
            PRESENT: begin
                if (out_ready) begin
                    accept    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            CFG_WR: begin
                cfg_fire  = 1'b1;
                state_nxt = CFG_WAIT;
            end
            CFG_WAIT: begin
                if (wait_cnt == 2'd3) begin
                    if (cfg_rd_sel == cfg_data) begin
                        ack_fire  = 1'b1;
                        state_nxt = IDLE;
                    end else if (attempt < 8'(CFG_RETRY)) begin
                        state_nxt = CFG_WR;
                    end else begin
                        ack_fire  = 1'b1;
                        err_val   = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_ch     <= '0;
            out_status <= '0;
            out_data   <= '0;
            rr         <= '0;
            ch_cfg_wr  <= '0;
            ch_wr_en   <= '0;
            wait_cnt   <= '0;
            attempt    <= '0;
            cfg_ack    <= 1'b0;
            cfg_err    <= 1'b0;
        end else begin
            if (grant_fire) begin
                out_valid  <= 1'b1;
                out_ch     <= grant_ch;
                out_status <= grant_status;
                out_data   <= grant_data;
                rr         <= grant_ch;
            end else if (accept) begin
                out_valid <= 1'b0;
            end
            if (cfg_fire) begin
                ch_cfg_wr <= cfg_data;
                wait_cnt  <= '0;
            end else if (state == CFG_WAIT) begin
                wait_cnt <= wait_cnt + 2'd1;
            end
            ch_wr_en <= cfg_fire ? cfg_onehot : '0;
            if (ack_fire)      attempt <= '0;
            else if (cfg_fire) attempt <= attempt + 8'd1;
            cfg_ack <= ack_fire;
            cfg_err <= ack_fire & err_val;
        end
    end

    assign irq = out_valid;

endmodule

// File: tb/tb_sl_rx_scheduler.sv
// Self-checking bench for sl_rx_scheduler: directed cases plus randomized events checked
// against a slot/round-robin reference model and a simple receiver config model.
module tb_sl_rx_scheduler;

    localparam int N_CH = 4;
    localparam int SW   = 16;
    localparam int CW   = 16;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [N_CH*SW-1:0]  ch_status;
    logic [N_CH*32-1:0]  ch_data;
    logic [N_CH-1:0]     ch_changed;
    logic [N_CH*CW-1:0]  ch_cfg_rd;
    logic [CW-1:0]       ch_cfg_wr;
    logic [N_CH-1:0]     ch_wr_en;
    logic                out_valid;
    logic                out_ready;
    logic [2:0]          out_ch;
    logic [SW-1:0]       out_status;
    logic [31:0]         out_data;
    logic [N_CH-1:0]     overrun;
    logic [N_CH-1:0]     overrun_clr;
    logic                cfg_req;
    logic [2:0]          cfg_ch;
    logic [CW-1:0]       cfg_data;
    logic                cfg_ack;
    logic                cfg_err;
    logic                irq;

    sl_rx_scheduler #(.N_CH(N_CH), .STATUS_WIDTH(SW), .CONFIG_WIDTH(CW), .CFG_RETRY(255)) dut (
        .clk(clk), .rst_n(rst_n), .ch_status(ch_status), .ch_data(ch_data), .ch_changed(ch_changed),
        .ch_cfg_rd(ch_cfg_rd), .ch_cfg_wr(ch_cfg_wr), .ch_wr_en(ch_wr_en), .out_valid(out_valid),
        .out_ready(out_ready), .out_ch(out_ch), .out_status(out_status), .out_data(out_data),
        .overrun(overrun), .overrun_clr(overrun_clr), .cfg_req(cfg_req), .cfg_ch(cfg_ch),
        .cfg_data(cfg_data), .cfg_ack(cfg_ack), .cfg_err(cfg_err), .irq(irq)
    );

    always #31 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Receiver config model: latches on strobe unless busy mid-word or the bit quantity is odd / below 8.
    logic [CW-1:0] rx_cfg [N_CH];
    int reject_left = 0;
    always @(posedge clk) begin
        for (int i = 0; i < N_CH; i++) begin
            if (ch_wr_en[i]) begin
                if (reject_left > 0) reject_left--;
                else if (ch_cfg_wr[5:1] >= 5'd8 && !ch_cfg_wr[1]) rx_cfg[i] <= ch_cfg_wr;
            end
        end
    end
    always_comb begin
        for (int i = 0; i < N_CH; i++) ch_cfg_rd[i*CW +: CW] = rx_cfg[i];
    end

    // Reference model: per-channel slot, pending and overrun flags, last granted channel.
    logic [N_CH-1:0] m_pending, m_ovr, cap_prev, clr_prev;
    logic [SW-1:0]   m_status [N_CH];
    logic [31:0]     m_data   [N_CH];
    logic [SW-1:0]   st_prev  [N_CH];
    logic [31:0]     dt_prev  [N_CH];
    int              m_rr;
    logic            prev_valid;
    logic [47:0]     held;
    int              strobe_cnt = 0;
    logic [N_CH-1:0] last_wr_en;
    int              grant_q[$];
    logic [31:0]     gdata_q[$];

    always @(negedge clk) begin
        int g;
        logic [SW-1:0] st;
        if (!rst_n) begin
            m_pending  = '0; m_ovr = '0; cap_prev = '0; clr_prev = '0;
            m_rr       = 0;
            prev_valid = 1'b0;
            for (int i = 0; i < N_CH; i++) begin
                m_status[i] = '0; m_data[i] = '0;
            end
        end else begin
            if (|ch_wr_en) begin
                strobe_cnt++;
                last_wr_en = ch_wr_en;
            end
            g = -1;
            if (out_valid && !prev_valid) begin
                for (int k = 1; k <= N_CH; k++)
                    if (g < 0 && m_pending[(m_rr + k) % N_CH]) g = (m_rr + k) % N_CH;
                check("grant_has_pending", 64'(g >= 0), 1);
                if (g >= 0) begin
                    check("grant_ch", out_ch, g);
                    check("grant_word", {out_status, out_data}, {m_status[g], m_data[g]});
                    m_pending[g] = 1'b0;
                    m_rr = g;
                    grant_q.push_back(g);
                    gdata_q.push_back(m_data[g]);
                end
                held = {out_status, out_data};
            end else if (out_valid && prev_valid) begin
                check("hold_word", {out_status, out_data}, held);
            end
            check("irq", irq, out_valid);
            m_ovr = m_ovr & ~clr_prev;
            for (int i = 0; i < N_CH; i++) begin
                if (cap_prev[i]) begin
                    if (m_pending[i]) m_ovr[i] = 1'b1;
                    m_pending[i] = 1'b1;
                    m_status[i]  = st_prev[i];
                    m_data[i]    = dt_prev[i];
                end
            end
            check("overrun", overrun, m_ovr);
            for (int i = 0; i < N_CH; i++) begin
                st          = ch_status[i*SW +: SW];
                cap_prev[i] = ch_changed[i] & (st[3] | st[5]);
                st_prev[i]  = st;
                dt_prev[i]  = ch_data[i*32 +: 32];
            end
            clr_prev   = overrun_clr;
            prev_valid = out_valid;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic send_event(input int ch, input logic [SW-1:0] st, input logic [31:0] d);
        ch_changed[ch]        = 1'b1;
        ch_status[ch*SW +: SW] = st;
        ch_data[ch*32 +: 32]  = d;
        tick();
        ch_changed = '0;
    endtask

    task automatic do_cfg(input string tag, input int ch, input logic [CW-1:0] d,
                          input int exp_strobes, input logic exp_err);
        logic got;
        got        = 1'b0;
        strobe_cnt = 0;
        cfg_ch     = 3'(ch);
        cfg_data   = d;
        cfg_req    = 1'b1;
        for (int n = 0; n < 3000 && !got; n++) begin
            @(negedge clk);
            if (cfg_ack) got = 1'b1;
        end
        check($sformatf("%s_ack", tag), got, 1);
        check($sformatf("%s_err", tag), cfg_err, exp_err);
        check($sformatf("%s_strobes", tag), strobe_cnt, exp_strobes);
        if (exp_strobes > 0) check($sformatf("%s_strobe_ch", tag), last_wr_en, 64'd1 << ch);
        if (exp_strobes > 0 && !exp_err) check($sformatf("%s_readback", tag), rx_cfg[ch], d);
        @(posedge clk);
        #1 cfg_req = 1'b0;
        @(negedge clk);
        check($sformatf("%s_ack_pulse", tag), cfg_ack, 0);
    endtask

    initial begin
        ch_status = '0; ch_data = '0; ch_changed = '0; out_ready = 1'b0;
        overrun_clr = '0; cfg_req = 1'b0; cfg_ch = '0; cfg_data = '0;
        for (int i = 0; i < N_CH; i++) rx_cfg[i] = '0;
        apply_reset();
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_irq", irq, 0);
        check("rst_wr_en", ch_wr_en, 0);
        check("rst_cfg_ack", {cfg_ack, cfg_err}, 0);
        check("rst_overrun", overrun, 0);

        // Single WRF event: out_valid three cycles after the capture edge, exactly one beat.
        out_ready = 1'b1;
        send_event(1, 16'h0008, 32'hDEADBEEF);
        @(negedge clk); check("lat_c1", out_valid, 0);
        tick(); @(negedge clk); check("lat_c2", out_valid, 0);
        tick(); @(negedge clk); check("lat_c3", out_valid, 1);
        check("lat_ch", out_ch, 1);
        check("lat_data", out_data, 32'hDEADBEEF);
        tick(); @(negedge clk); check("one_beat", out_valid, 0);

        // Simultaneous events on 0, 2, 3 with rr=0.
        apply_reset();
        grant_q.delete(); gdata_q.delete();
        ch_changed = 4'b1101;
        ch_status  = {16'h0008, 16'h0020, 16'h0008, 16'h0008};
        ch_data    = {32'h33, 32'h22, 32'h11, 32'h00};
        tick();
        ch_changed = '0;
        repeat (20) tick();
        check("rr_count", grant_q.size(), 3);
        check("rr_first", grant_q[0], 2);
        check("rr_second", grant_q[1], 3);
        check("rr_third", grant_q[2], 0);

        // Overrun on ch2 while the host stalls.
        apply_reset();
        grant_q.delete(); gdata_q.delete();
        out_ready = 1'b0;
        send_event(2, 16'h0008, 32'hAAAA0001);
        repeat (4) tick();
        send_event(2, 16'h0008, 32'hAAAA0002);
        send_event(2, 16'h0020, 32'hAAAA0003);
        @(negedge clk); check("ovr_set", overrun[2], 1);
        out_ready = 1'b1;
        repeat (12) tick();
        check("ovr_words", gdata_q.size(), 2);
        check("ovr_first", gdata_q[0], 32'hAAAA0001);
        check("ovr_second", gdata_q[1], 32'hAAAA0003);
        check("ovr_sticky", overrun[2], 1);
        overrun_clr = 4'b0100;
        tick();
        overrun_clr = '0;
        @(negedge clk); check("ovr_clr", overrun[2], 0);

        // Config sequences.
        reject_left = 0;
        do_cfg("cfg_ok", 0, 16'h0010, 1, 1'b0);
        reject_left = 2;
        do_cfg("cfg_retry", 3, 16'h0030, 3, 1'b0);
        reject_left = 0;
        do_cfg("cfg_bq7", 1, 16'h000E, 255, 1'b1);
        do_cfg("cfg_badch", 5, 16'h0010, 0, 1'b1);

        // WRP-only change is not an event.
        out_ready = 1'b1;
        send_event(1, 16'h0010, 32'h12345678);
        for (int n = 0; n < 6; n++) begin
            @(negedge clk); check("wrp_ignored", out_valid, 0);
            tick();
        end

        // Asynchronous reset while a word is being presented.
        out_ready = 1'b0;
        send_event(3, 16'h0020, 32'h0BADF00D);
        repeat (4) tick();
        @(negedge clk); check("pres_valid", out_valid, 1);
        #5 rst_n = 1'b0;
        #1 check("arst_valid", {out_valid, irq}, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) tick();
        @(negedge clk); check("arst_slots_lost", out_valid, 0);

        // Randomized traffic checked by the model.
        apply_reset();
        for (int cyc = 0; cyc < 800; cyc++) begin
            for (int i = 0; i < N_CH; i++) begin
                ch_changed[i]        = ($urandom_range(0, 3) == 0);
                ch_status[i*SW +: SW] = SW'($urandom);
                ch_data[i*32 +: 32]  = $urandom;
                overrun_clr[i]       = ($urandom_range(0, 15) == 0);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        ch_changed = '0; overrun_clr = '0; out_ready = 1'b1;
        repeat (40) tick();
        @(negedge clk);
        check("drain_pending", m_pending, 0);
        check("drain_valid", out_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
